// File: rtl/conv_wreg_bank_pkg.sv
// Shared defaults and FSM state type for the double-buffered convolution weight register.
package conv_wreg_bank_pkg;

  localparam int unsigned DWIDTH_DEF = 16;
  localparam int unsigned FSIZE_DEF  = 5;
  localparam int unsigned K_DEF      = FSIZE_DEF * FSIZE_DEF;

  typedef enum logic {
    LOADING = 1'b0,
    FULL    = 1'b1
  } wreg_state_e;

endpackage

// File: rtl/wreg_shift_chain.sv
// Serial-in, parallel-out shift chain: new words enter at the top tap and move toward tap 0.
module wreg_shift_chain #(
  parameter int unsigned DEPTH = 25,
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [WIDTH-1:0]       din,
  output logic [DEPTH*WIDTH-1:0] dout
);

  logic [DEPTH*WIDTH-1:0] chain;

  // Tap i sits at bits [i*WIDTH +: WIDTH]; a shift drops tap 0 and lands din in tap DEPTH-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else if (en) begin
      chain <= {din, chain[DEPTH*WIDTH-1:WIDTH]};
    end
  end

  assign dout = chain;

endmodule

// File: rtl/conv_wreg_bank.sv
// Double-buffered FSIZE x FSIZE weight bank: shadow loads serially while the active bank feeds the MAC array.
module conv_wreg_bank
  import conv_wreg_bank_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned FSIZE  = FSIZE_DEF,
  parameter int unsigned CWIDTH = $clog2(FSIZE * FSIZE + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [DWIDTH-1:0]        read_data,
  input  logic                            wreg_we,
  input  logic                            wreg_swap,
  output logic [FSIZE*FSIZE*DWIDTH-1:0]   weight,
  output logic                            shadow_full,
  output logic                            active_valid,
  output logic [CWIDTH-1:0]               load_count,
  output logic                            overflow
);

  localparam int unsigned K = FSIZE * FSIZE;
  localparam logic [CWIDTH-1:0] K_CNT = CWIDTH'(K);

  wreg_state_e              state, state_n;
  logic [CWIDTH-1:0]        count_n;
  logic                     accept_we;
  logic                     accept_swap;
  logic                     overflow_set;
  logic [K*DWIDTH-1:0]      shadow;
  logic [K*DWIDTH-1:0]      active;

  wreg_shift_chain #(
    .DEPTH (K),
    .WIDTH (DWIDTH)
  ) u_shadow (
    .clk  (clk),
    .rst  (rst),
    .en   (accept_we),
    .din  (read_data),
    .dout (shadow)
  );

  // A swap in FULL frees the shadow, so a same-cycle write becomes word 1 of the next kernel.
  always_comb begin
    state_n      = state;
    count_n      = load_count;
    accept_swap  = 1'b0;
    accept_we    = 1'b0;
    overflow_set = 1'b0;
    unique case (state)
      LOADING: begin
        if (wreg_we) begin
          accept_we = 1'b1;
          count_n   = load_count + 1'b1;
        end
      end
      FULL: begin
        if (wreg_swap) begin
          accept_swap = 1'b1;
          accept_we   = wreg_we;
          count_n     = CWIDTH'(wreg_we);
        end else if (wreg_we) begin
          overflow_set = 1'b1;
        end
      end
      default: ;
    endcase
    if (accept_we || accept_swap) begin
      state_n = (count_n == K_CNT) ? FULL : LOADING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOADING;
      load_count   <= '0;
      active       <= '0;
      active_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state      <= state_n;
      load_count <= count_n;
      if (accept_swap) begin
        active       <= shadow;
        active_valid <= 1'b1;
      end
      if (overflow_set) begin
        overflow <= 1'b1;
      end
    end
  end

  assign weight      = active;
  assign shadow_full = (state == FULL);

endmodule

// File: tb/tb_conv_wreg_bank.sv
// Directed bench for conv_wreg_bank: a queue-based kernel model checked every cycle, plus literal pins.
module tb_conv_wreg_bank;

  localparam int unsigned DW = 16;
  localparam int unsigned FS = 5;
  localparam int unsigned K  = FS * FS;
  localparam int unsigned CW = $clog2(K + 1);

  logic                   clk;
  logic                   rst;
  logic signed [DW-1:0]   read_data;
  logic                   wreg_we;
  logic                   wreg_swap;
  logic [K*DW-1:0]        weight;
  logic                   shadow_full;
  logic                   active_valid;
  logic [CW-1:0]          load_count;
  logic                   overflow;

  conv_wreg_bank #(
    .DWIDTH (DW),
    .FSIZE  (FS),
    .CWIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .read_data    (read_data),
    .wreg_we      (wreg_we),
    .wreg_swap    (wreg_swap),
    .weight       (weight),
    .shadow_full  (shadow_full),
    .active_valid (active_valid),
    .load_count   (load_count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Model: words written since the last swap, in arrival order; a swap hands them over as taps 0..K-1.
  logic signed [DW-1:0] m_pending[$];
  logic signed [DW-1:0] m_active[K];
  bit                   m_valid;
  bit                   m_ovf;

  function automatic int tap(input int unsigned i);
    logic signed [DW-1:0] w;
    w = weight[i*DW +: DW];
    return int'(w);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_pending.delete();
    for (int i = 0; i < int'(K); i++) m_active[i] = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit we, input bit sw, input logic signed [DW-1:0] d);
    bit full;
    if (r) begin
      model_reset();
      return;
    end
    full = (m_pending.size() == int'(K));
    if (full && sw) begin
      for (int i = 0; i < int'(K); i++) m_active[i] = m_pending[i];
      m_valid = 1'b1;
      m_pending.delete();
      if (we) m_pending.push_back(d);
    end else if (we) begin
      if (full) m_ovf = 1'b1;
      else m_pending.push_back(d);
    end
  endtask

  task automatic compare_model();
    int bad_tap;
    bad_tap = -1;
    for (int i = 0; i < int'(K); i++) begin
      if (bad_tap < 0 && tap(i) != int'(m_active[i])) bad_tap = i;
    end
    tests++;
    if (bad_tap >= 0) begin
      fails++;
      $display("FAIL weight[%0d]: got %0d, expected %0d", bad_tap, tap(bad_tap), int'(m_active[bad_tap]));
    end
    check("load_count", int'(load_count), m_pending.size());
    check("shadow_full", int'(shadow_full), int'(m_pending.size() == int'(K)));
    check("active_valid", int'(active_valid), int'(m_valid));
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic step(input bit r, input bit we, input bit sw, input int d);
    rst       = r;
    wreg_we   = we;
    wreg_swap = sw;
    read_data = DW'(d);
    @(posedge clk);
    model_edge(r, we, sw, DW'(d));
    #1;
    compare_model();
  endtask

  task automatic write_run(input int first, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, first + i);
  endtask

  int neg_seen;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; wreg_we = 1'b0; wreg_swap = 1'b0; read_data = '0;
    model_reset();

    // Reset with a concurrent write/swap, then idle.
    step(1'b1, 1'b1, 1'b1, 55);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0);
    check("rst_count", int'(load_count), 0);
    check("rst_tap0", tap(0), 0);
    check("rst_flags", int'({shadow_full, active_valid, overflow}), 0);

    // Full kernel 1..25 then swap.
    write_run(1, 25);
    check("fill_full", int'(shadow_full), 1);
    check("fill_count", int'(load_count), 25);
    step(1'b0, 1'b0, 1'b1, 0);
    check("swap_tap0", tap(0), 1);
    check("swap_tap24", tap(24), 25);
    check("swap_valid", int'(active_valid), 1);
    check("swap_count", int'(load_count), 0);
    check("swap_full", int'(shadow_full), 0);

    // Partial-load swap is ignored.
    write_run(100, 10);
    step(1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 0);
    check("partial_count", int'(load_count), 10);
    check("partial_tap0", tap(0), 1);

    // Finish the kernel, then overflow with -7.
    write_run(110, 15);
    step(1'b0, 1'b1, 1'b0, -7);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_count", int'(load_count), 25);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 0);
    check("ovf_tap0", tap(0), 100);
    check("ovf_tap24", tap(24), 124);
    neg_seen = 0;
    for (int i = 0; i < int'(K); i++) if (tap(i) == -7) neg_seen++;
    check("ovf_no_neg7", neg_seen, 0);
    check("ovf_sticky", int'(overflow), 1);

    // Swap coinciding with the first write of the next kernel.
    step(1'b1, 1'b0, 1'b0, 0);
    check("rst2_ovf", int'(overflow), 0);
    write_run(200, 25);
    step(1'b0, 1'b1, 1'b1, 99);
    check("coinc_count", int'(load_count), 1);
    check("coinc_ovf", int'(overflow), 0);
    check("coinc_tap0", tap(0), 200);
    check("coinc_tap24", tap(24), 224);
    write_run(300, 24);
    step(1'b0, 1'b0, 1'b1, 0);
    check("next_tap0", tap(0), 99);
    check("next_tap1", tap(1), 300);
    check("next_tap24", tap(24), 323);

    // Reset mid-load discards the partial kernel.
    write_run(400, 12);
    step(1'b1, 1'b0, 1'b0, 0);
    check("midrst_count", int'(load_count), 0);
    check("midrst_tap0", tap(0), 0);
    write_run(500, 25);
    step(1'b0, 1'b0, 1'b1, 0);
    check("fresh_tap0", tap(0), 500);
    check("fresh_tap12", tap(12), 512);
    check("fresh_tap24", tap(24), 524);
    check("fresh_valid", int'(active_valid), 1);

    // Signed extremes survive the chain.
    write_run(-32768, 1);
    write_run(32767, 24);
    step(1'b0, 1'b0, 1'b1, 0);
    check("sign_tap0", tap(0), -32768);
    check("sign_tap24", tap(24), 32767 + 23 - 65536);
    step(1'b0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
